module_display_mux: RTL

Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display. It latches an N-nibble hex value plus per-digit decimal points, scans the digits at a configurable rate with an anti-ghosting blank window, and optionally suppresses leading zeros. It sits between the datapath that produces the values and the board's segment and anode pins, and replaces per-digit static decoders.

---
 rtl/module_display_mux.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/module_display_mux.sv
// Time-multiplexed N-digit 7-segment driver: shadowed hex value, leading-zero suppression, anti-ghost blanking.
// Latency: one cycle from scan position/shadow to pins; a load is visible on the next edge when its digit is selected.
// No backpressure: load is accepted unconditionally and scanning never stalls.
module module_display_mux #(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = 27000,
  parameter int BLANK_CYC      = 270,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  blank_lz,
  input  logic                  enable,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [6:0]          SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic                DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{AN_ACTIVE_LOW}};

  logic [4*N_DIGITS-1:0] shadow;
  logic [N_DIGITS-1:0]   shadow_dp;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;

  logic [N_DIGITS-1:0]   upper_zero;
  logic                  zero_run;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_lz;
  logic [6:0]            seg_lo;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [N_DIGITS-1:0]   an_hot;
  logic [N_DIGITS-1:0]   an_d;
  logic                  in_blank;

  // Active-low a..g codes, a in the MSB.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] code;
    case (v)
      4'h0:    code = 7'b0000001;
      4'h1:    code = 7'b1001111;
      4'h2:    code = 7'b0010010;
      4'h3:    code = 7'b0000110;
      4'h4:    code = 7'b1001100;
      4'h5:    code = 7'b0100100;
      4'h6:    code = 7'b0100000;
      4'h7:    code = 7'b0001111;
      4'h8:    code = 7'b0000000;
      4'h9:    code = 7'b0000100;
      4'hA:    code = 7'b0001000;
      4'hB:    code = 7'b1100000;
      4'hC:    code = 7'b0110001;
      4'hD:    code = 7'b1000010;
      4'hE:    code = 7'b0110000;
      default: code = 7'b0111000;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      shadow_dp <= '0;
    end else if (load) begin
      shadow    <= data_in;
      shadow_dp <= dp_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // upper_zero[i]: every nibble from i up to the top digit is zero.
  always_comb begin
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (shadow[4*i +: 4] == 4'h0);
      upper_zero[i] = zero_run;
    end
  end

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib = shadow[4*i +: 4];
        cur_dp  = shadow_dp[i];
        cur_lz  = (i != 0) && upper_zero[i];
      end
    end
  end

  always_comb begin
    in_blank = (BLANK_CYC > 0) && (int'(cnt) < BLANK_CYC);
    seg_lo   = (blank_lz && cur_lz) ? 7'h7F : hex7(cur_nib);
    seg_d    = SEG_ACTIVE_LOW ? seg_lo : ~seg_lo;
    dp_d     = SEG_ACTIVE_LOW ? ~cur_dp : cur_dp;
    an_hot   = '0;
    if (enable && !in_blank) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        an_hot[i] = (idx == IDX_W'(i));
      end
    end
    an_d = AN_ACTIVE_LOW ? ~an_hot : an_hot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_d;
      dp         <= dp_d;
      an         <= an_d;
      frame_tick <= (idx == '0) && (cnt == '0);
    end
  end

endmodule
